// File: rtl/apb3_arbiter_2to1.sv
// Purpose : shares one APB3 completer between two APB3 requesters, granting whole transfers round-robin.
// Latency : completer SETUP one cycle after the request is sampled in IDLE, ACCESS the cycle after; 3 cycles minimum per transfer.
// Backpres: losing requester is held in a legal APB wait (pready=0); a hung completer is cut off with PSLVERR after TimeoutCycles.
module apb3_arbiter_2to1 #(
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s0_psel,
    input  logic                    s0_penable,
    input  logic                    s0_pwrite,
    input  logic [AddressWidth-1:0] s0_paddr,
    input  logic [DataWidth-1:0]    s0_pwdata,
    output logic [DataWidth-1:0]    s0_prdata,
    output logic                    s0_pready,
    output logic                    s0_pslverr,
    input  logic                    s1_psel,
    input  logic                    s1_penable,
    input  logic                    s1_pwrite,
    input  logic [AddressWidth-1:0] s1_paddr,
    input  logic [DataWidth-1:0]    s1_pwdata,
    output logic [DataWidth-1:0]    s1_prdata,
    output logic                    s1_pready,
    output logic                    s1_pslverr,
    output logic                    m_psel,
    output logic                    m_penable,
    output logic                    m_pwrite,
    output logic [AddressWidth-1:0] m_paddr,
    output logic [DataWidth-1:0]    m_pwdata,
    input  logic [DataWidth-1:0]    m_prdata,
    input  logic                    m_pready,
    input  logic                    m_pslverr,
    output logic                    timeout
);

    localparam bit TimeoutEn = (TimeoutCycles > 0);
    localparam int CntWidth  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntWidth-1:0] CntLast =
        (TimeoutCycles > 0) ? CntWidth'(TimeoutCycles - 1) : '0;

    // Encoding chosen so bit 0 is m_psel and bit 1 is m_penable straight off the flops.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b11
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                grant;
    logic                last_grant;
    logic                pick;
    logic                req_any;
    logic                tmo_hit;
    logic                xfer_done;
    logic                resp_en;
    logic [CntWidth-1:0] wait_cnt;

    // penable of a requester carries no information the arbiter needs: a request is psel in IDLE.
    logic unused_penable;
    assign unused_penable = s0_penable ^ s1_penable;

    assign req_any   = s0_psel | s1_psel;
    // Tie goes to the requester that did not finish last; otherwise the lone requester.
    assign pick      = (s0_psel & s1_psel) ? ~last_grant : (s1_psel & ~s0_psel);
    assign tmo_hit   = TimeoutEn && (state == ACCESS) && !m_pready && (wait_cnt == CntLast);
    assign xfer_done = (state == ACCESS) && (m_pready || tmo_hit);
    assign resp_en   = !rst && (state == ACCESS);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: whole-transfer grant, fixed SETUP, ACCESS until ready or timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_any) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (xfer_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: completer strobes from state bits, responses steered to the granted requester
    always_comb begin
        m_psel     = state[0];
        m_penable  = state[1];
        s0_pready  = 1'b0;
        s0_pslverr = 1'b0;
        s0_prdata  = '0;
        s1_pready  = 1'b0;
        s1_pslverr = 1'b0;
        s1_prdata  = '0;
        timeout    = !rst && tmo_hit;
        if (resp_en && !grant) begin
            s0_pready  = m_pready || tmo_hit;
            s0_pslverr = m_pready ? m_pslverr : tmo_hit;
            s0_prdata  = tmo_hit ? '0 : m_prdata;
        end
        if (resp_en && grant) begin
            s1_pready  = m_pready || tmo_hit;
            s1_pslverr = m_pready ? m_pslverr : tmo_hit;
            s1_prdata  = tmo_hit ? '0 : m_prdata;
        end
    end

    // Grant bookkeeping, completer command capture and ACCESS wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            m_pwrite   <= 1'b0;
            m_paddr    <= '0;
            m_pwdata   <= '0;
        end else begin
            if (state == IDLE && req_any) begin
                grant    <= pick;
                m_pwrite <= pick ? s1_pwrite : s0_pwrite;
                m_paddr  <= pick ? s1_paddr  : s0_paddr;
                m_pwdata <= pick ? s1_pwdata : s0_pwdata;
            end
            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if (state == ACCESS && !m_pready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (xfer_done) begin
                last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_apb3_arbiter_2to1.sv
// Directed bench for the 2:1 APB3 arbiter with a small behavioural memory completer.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Latency figures below count cycles from the cycle psel is first driven (that cycle = 0).
module tb_apb3_arbiter_2to1;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s0_psel = 1'b0, s0_penable = 1'b0, s0_pwrite = 1'b0;
    logic [AW-1:0] s0_paddr = '0;
    logic [DW-1:0] s0_pwdata = '0;
    logic [DW-1:0] s0_prdata;
    logic          s0_pready, s0_pslverr;
    logic          s1_psel = 1'b0, s1_penable = 1'b0, s1_pwrite = 1'b0;
    logic [AW-1:0] s1_paddr = '0;
    logic [DW-1:0] s1_pwdata = '0;
    logic [DW-1:0] s1_prdata;
    logic          s1_pready, s1_pslverr;
    logic          m_psel, m_penable, m_pwrite;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata, m_prdata;
    logic          m_pready, m_pslverr;
    logic          timeout;

    always #5 clk = ~clk;

    apb3_arbiter_2to1 #(
        .AddressWidth (AW),
        .DataWidth    (DW),
        .TimeoutCycles(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s0_psel   (s0_psel),
        .s0_penable(s0_penable),
        .s0_pwrite (s0_pwrite),
        .s0_paddr  (s0_paddr),
        .s0_pwdata (s0_pwdata),
        .s0_prdata (s0_prdata),
        .s0_pready (s0_pready),
        .s0_pslverr(s0_pslverr),
        .s1_psel   (s1_psel),
        .s1_penable(s1_penable),
        .s1_pwrite (s1_pwrite),
        .s1_paddr  (s1_paddr),
        .s1_pwdata (s1_pwdata),
        .s1_prdata (s1_prdata),
        .s1_pready (s1_pready),
        .s1_pslverr(s1_pslverr),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr),
        .timeout   (timeout)
    );

    // Behavioural completer: word memory, programmable wait states, stuck or error modes
    logic [DW-1:0] mem [0:255];
    int wait_states = 0;
    bit never_ready = 1'b0;
    bit err_flag    = 1'b0;
    int wcnt        = 0;

    assign m_pready  = m_psel && m_penable && !never_ready && (wcnt >= wait_states);
    assign m_pslverr = m_pready && err_flag;
    assign m_prdata  = mem[m_paddr[9:2]];

    always @(posedge clk) begin
        if (m_psel && m_penable && m_pready && m_pwrite) mem[m_paddr[9:2]] <= m_pwdata;
        if (m_psel && m_penable && !m_pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    // Bus monitor: grant order, psel occupancy, command stability, timeout placement
    logic [AW:0]   setup_q [$];
    logic [AW-1:0] lat_addr = '0;
    logic [DW-1:0] lat_wdata = '0;
    int psel_cycles = 0, acc_run = 0, tmo_acc = 0, tmo_cnt = 0, stable_bad = 0;
    int s1_rdy_cnt = 0, s1_err_cnt = 0;
    bit tmo_prev = 1'b0, psel_after_tmo = 1'b1;

    always @(negedge clk) begin
        if (m_psel) psel_cycles <= psel_cycles + 1;
        if (m_psel && !m_penable) begin
            setup_q.push_back({m_pwrite, m_paddr});
            lat_addr  <= m_paddr;
            lat_wdata <= m_pwdata;
        end
        if (m_psel && m_penable) begin
            acc_run <= acc_run + 1;
            if (m_paddr != lat_addr || m_pwdata != lat_wdata) stable_bad <= stable_bad + 1;
        end else begin
            acc_run <= 0;
        end
        if (tmo_prev) psel_after_tmo <= m_psel;
        tmo_prev <= timeout;
        if (timeout) begin
            tmo_cnt <= tmo_cnt + 1;
            tmo_acc <= acc_run + 1;
        end
        if (s1_pready)  s1_rdy_cnt <= s1_rdy_cnt + 1;
        if (s1_pslverr) s1_err_cnt <= s1_err_cnt + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int id, input bit sel, input bit en, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id == 0) begin
            s0_psel = sel; s0_penable = en; s0_pwrite = wr; s0_paddr = a; s0_pwdata = d;
        end else begin
            s1_psel = sel; s1_penable = en; s1_pwrite = wr; s1_paddr = a; s1_pwdata = d;
        end
    endtask

    // Called at the start of a cycle; returns at the start of the cycle after completion
    // with psel dropped. lat stays -1 if the transfer never completes within the budget.
    task automatic xfer(input int id, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                        output bit err, output int lat);
        int k;
        lat   = -1;
        rdata = '0;
        err   = 1'b0;
        drive(id, 1'b1, 1'b0, wr, addr, wdata);
        @(posedge clk); #1;
        drive(id, 1'b1, 1'b1, wr, addr, wdata);
        k = 1;
        while (k < 60) begin
            @(negedge clk);
            if ((id == 0) ? s0_pready : s1_pready) begin
                lat   = k;
                rdata = (id == 0) ? s0_prdata : s1_prdata;
                err   = (id == 0) ? s0_pslverr : s1_pslverr;
                break;
            end
            @(posedge clk); #1;
            k++;
        end
        if (lat < 0) $display("FAIL xfer%0d_budget: got=no pready exp=pready", id);
        @(posedge clk); #1;
        drive(id, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd0, rd1;
        bit e0, e1;
        int l0, l1, lat_first;
        int snap_a, snap_b, qbase;
        logic [AW:0] exp_q;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_m_psel",    64'(m_psel),    64'(0));
        check("rst_m_penable", 64'(m_penable), 64'(0));
        check("rst_m_pwrite",  64'(m_pwrite),  64'(0));
        check("rst_m_paddr",   64'(m_paddr),   64'(0));
        check("rst_m_pwdata",  64'(m_pwdata),  64'(0));
        check("rst_timeout",   64'(timeout),   64'(0));
        check("rst_s0_pready", 64'(s0_pready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Single write then read from requester 0
        snap_a = s1_rdy_cnt;
        xfer(0, 1'b1, AW'(32'h00010), 32'hDEADBEEF, rd0, e0, l0);
        check("wr_latency", 64'(l0), 64'(2));
        xfer(0, 1'b0, AW'(32'h00010), 32'h0, rd0, e0, l0);
        check("rd_latency", 64'(l0), 64'(2));
        check("rd_data", 64'(rd0), 64'(32'hDEADBEEF));
        check("s1_never_ready", 64'(s1_rdy_cnt - snap_a), 64'(0));

        // Reset in ACCESS while the completer is ready: responses masked, bus dropped
        s0_psel = 1'b1; s0_pwrite = 1'b0; s0_paddr = AW'(32'h00010);
        @(posedge clk); #1;
        s0_penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstacc_s0_pready", 64'(s0_pready), 64'(0));
        check("rstacc_s0_prdata", 64'(s0_prdata), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0; s0_psel = 1'b0; s0_penable = 1'b0; s0_paddr = '0;
        @(negedge clk);
        check("rstacc_m_psel",    64'(m_psel),    64'(0));
        check("rstacc_m_penable", 64'(m_penable), 64'(0));
        check("rstacc_m_paddr",   64'(m_paddr),   64'(0));
        @(posedge clk); #1;

        // Tie right after reset, 4 back-to-back transfers each: 0 writes, 1 reads back
        qbase     = setup_q.size();
        snap_a    = psel_cycles;
        lat_first = -1;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    xfer(0, 1'b1, AW'(32'h100 + 4 * i), 32'h1000 + i, rd0, e0, l0);
                    if (i == 0) lat_first = l0;
                end
            end
            begin
                for (int j = 0; j < 4; j++) xfer(1, 1'b0, AW'(32'h100 + 4 * j), 32'h0, rd1, e1, l1);
            end
        join
        check("rr_first_latency", 64'(lat_first), 64'(2));
        for (int g = 0; g < 8; g++) begin
            exp_q = {((g % 2) == 0), AW'(32'h100 + 4 * (g / 2))};
            check($sformatf("rr_order%0d", g),
                  64'((setup_q.size() > qbase + g) ? setup_q[qbase + g] : '1), 64'(exp_q));
        end
        check("rr_psel_cycles", 64'(psel_cycles - snap_a), 64'(16));
        check("rr_s1_rdata", 64'(rd1), 64'(32'h1003));

        // 3 completer wait states; requester 1 arrives one cycle later and is stalled
        wait_states = 3;
        snap_a      = stable_bad;
        snap_b      = tmo_cnt;
        fork
            xfer(0, 1'b1, AW'(32'h00020), 32'hCAFE0001, rd0, e0, l0);
            begin
                @(posedge clk); #1;
                xfer(1, 1'b0, AW'(32'h00010), 32'h0, rd1, e1, l1);
            end
        join
        wait_states = 0;
        check("ws_s0_latency", 64'(l0), 64'(5));
        check("ws_s0_pslverr", 64'(e0), 64'(0));
        check("ws_s1_latency", 64'(l1), 64'(10));
        check("ws_s1_rdata",   64'(rd1), 64'(32'hDEADBEEF));
        check("ws_cmd_stable", 64'(stable_bad - snap_a), 64'(0));
        check("ws_no_timeout", 64'(tmo_cnt - snap_b), 64'(0));

        // Completer error response goes to the granted requester only
        err_flag = 1'b1;
        snap_a   = s1_err_cnt;
        snap_b   = tmo_cnt;
        xfer(0, 1'b1, AW'(32'h00030), 32'h5A5A5A5A, rd0, e0, l0);
        err_flag = 1'b0;
        check("err_s0_pslverr", 64'(e0), 64'(1));
        check("err_latency",    64'(l0), 64'(2));
        check("err_no_timeout", 64'(tmo_cnt - snap_b), 64'(0));
        check("err_s1_clean",   64'(s1_err_cnt - snap_a), 64'(0));

        // Hung completer: forced error in ACCESS cycle 4, then pending requester 1 served
        never_ready = 1'b1;
        snap_b      = tmo_cnt;
        fork
            begin
                xfer(0, 1'b0, AW'(32'h00010), 32'h0, rd0, e0, l0);
                never_ready = 1'b0;
            end
            begin
                @(posedge clk); #1;
                xfer(1, 1'b0, AW'(32'h00100), 32'h0, rd1, e1, l1);
            end
        join
        check("tmo_s0_latency",  64'(l0), 64'(5));
        check("tmo_s0_pslverr",  64'(e0), 64'(1));
        check("tmo_s0_prdata",   64'(rd0), 64'(0));
        check("tmo_pulses",      64'(tmo_cnt - snap_b), 64'(1));
        check("tmo_access_cyc",  64'(tmo_acc), 64'(4));
        check("tmo_psel_after",  64'(psel_after_tmo), 64'(0));
        check("tmo_s1_latency",  64'(l1), 64'(7));
        check("tmo_s1_rdata",    64'(rd1), 64'(32'h1000));
        check("tmo_s1_pslverr",  64'(e1), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
